// File: rtl/cla_pkg.sv
// Shared helpers for the pipelined carry-lookahead adder: parameter checks,
// group count and the (P, G) lookahead reduction used at bit and group level.
package cla_pkg;

    // Widest p/g vector the lookahead reduction accepts (bits or groups).
    localparam int LA_MAXW = 128;

    function automatic bit group_ok(input int grp);
        return (grp == 2) || (grp == 4) || (grp == 8);
    endfunction

    function automatic int ngroups(input int width, input int grp);
        return width / grp;
    endfunction

    // Returns {P, G} over the lowest n entries; n == 0 yields {1, 0}.
    function automatic logic [1:0] lookahead(input logic [LA_MAXW-1:0] pv,
                                             input logic [LA_MAXW-1:0] gv,
                                             input int n);
        logic pp;
        logic gg;
        pp = 1'b1;
        gg = 1'b0;
        for (int i = 0; i < LA_MAXW; i++) begin
            if (i < n) begin
                gg = gv[i] | (pv[i] & gg);
                pp = pp & pv[i];
            end
        end
        return {pp, gg};
    endfunction

endpackage

// File: rtl/cla_pipe_group.sv
// One lookahead group: carry into every bit from the group carry-in,
// plus the group propagate/generate pair.
module cla_group
    import cla_pkg::*;
#(
    parameter int GROUP = 4
) (
    input  logic [GROUP-1:0] p_i,
    input  logic [GROUP-1:0] g_i,
    input  logic             c_i,
    output logic [GROUP-1:0] c_o,
    output logic             gp_o,
    output logic             gg_o
);

    always_comb begin
        logic [LA_MAXW-1:0] pv;
        logic [LA_MAXW-1:0] gv;
        logic [1:0]         pg;
        pv = '0;
        gv = '0;
        pv[GROUP-1:0] = p_i;
        gv[GROUP-1:0] = g_i;
        c_o = '0;
        // Each bit carry is a flat lookahead over the bits below it.
        for (int i = 0; i < GROUP; i++) begin
            pg = lookahead(pv, gv, i);
            c_o[i] = pg[0] | (pg[1] & c_i);
        end
        pg = lookahead(pv, gv, GROUP);
        gp_o = pg[1];
        gg_o = pg[0];
    end

endmodule

// File: rtl/cla_pipe.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready on both
// sides. Define CLA_FLAGS_EN to add the registered ovf and zero outputs.
module cla_pipe
    import cla_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef CLA_FLAGS_EN
    ,
    output logic             ovf,
    output logic             zero
`endif
);

    localparam int NG = ngroups(WIDTH, GROUP);

    if (!group_ok(GROUP) || (WIDTH % GROUP) != 0 || WIDTH < GROUP) begin : g_param_err
        $error("cla_pipe: GROUP must be 2, 4 or 8 and WIDTH a non-zero multiple of GROUP");
    end

    // Handshake: a beat moves when valid & ready; each stage advances when the
    // stage after it is empty or draining this cycle.
    logic adv1, adv2, in_fire;
    logic s1_valid_q, out_valid_q;

    logic [WIDTH-1:0] b_eff, p_d, g_d, p_q, g_q;
    logic [NG-1:0]    gp_d, gg_d, gp_q, gg_q;
    logic             c0_d, c0_q;
    logic [NG-1:0]    gc, gp_s2, gg_s2;
    logic [WIDTH-1:0] carry, sum_d, sum_q;
    logic             cout_d, cout_q;

    assign adv2     = !out_valid_q | out_ready;
    assign adv1     = !s1_valid_q | adv2;
    assign in_ready = adv1 & !rst;
    assign in_fire  = in_valid & in_ready;

    // Stage 1: bit propagate/generate and group-level P/G.
    assign b_eff = sub ? ~inB : inB;
    assign c0_d  = sub | cin;
    assign p_d   = inA ^ b_eff;
    assign g_d   = inA & b_eff;

    always_comb begin
        logic [LA_MAXW-1:0] pv;
        logic [LA_MAXW-1:0] gv;
        logic [1:0]         pg;
        pv   = '0;
        gv   = '0;
        pg   = '0;
        gp_d = '0;
        gg_d = '0;
        for (int k = 0; k < NG; k++) begin
            pv = '0;
            gv = '0;
            pv[GROUP-1:0] = p_d[k*GROUP +: GROUP];
            gv[GROUP-1:0] = g_d[k*GROUP +: GROUP];
            pg = lookahead(pv, gv, GROUP);
            gp_d[k] = pg[1];
            gg_d[k] = pg[0];
        end
    end

    // Stage 2: second-level lookahead gives every group its carry-in.
    always_comb begin
        logic [LA_MAXW-1:0] pv;
        logic [LA_MAXW-1:0] gv;
        logic [1:0]         pg;
        pv = '0;
        gv = '0;
        pv[NG-1:0] = gp_q;
        gv[NG-1:0] = gg_q;
        gc = '0;
        for (int k = 0; k < NG; k++) begin
            pg = lookahead(pv, gv, k);
            gc[k] = pg[0] | (pg[1] & c0_q);
        end
    end

    for (genvar k = 0; k < NG; k++) begin : g_grp
        cla_group #(.GROUP(GROUP)) u_grp (
            .p_i  (p_q[k*GROUP +: GROUP]),
            .g_i  (g_q[k*GROUP +: GROUP]),
            .c_i  (gc[k]),
            .c_o  (carry[k*GROUP +: GROUP]),
            .gp_o (gp_s2[k]),
            .gg_o (gg_s2[k])
        );
    end

    // Word carry-out: lookahead across the group outputs of stage 2.
    always_comb begin
        logic [LA_MAXW-1:0] pv;
        logic [LA_MAXW-1:0] gv;
        logic [1:0]         pg;
        pv = '0;
        gv = '0;
        pv[NG-1:0] = gp_s2;
        gv[NG-1:0] = gg_s2;
        pg = lookahead(pv, gv, NG);
        cout_d = pg[0] | (pg[1] & c0_q);
    end

    assign sum_d = p_q ^ carry;

`ifdef CLA_FLAGS_EN
    logic a_msb_q, b_msb_q, ovf_q, zero_q;
    logic ovf_d, zero_d;
    assign ovf_d  = (a_msb_q == b_msb_q) & (sum_d[WIDTH-1] != a_msb_q);
    assign zero_d = ~|sum_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
`ifdef CLA_FLAGS_EN
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
`endif
        end else begin
            if (adv1) begin
                s1_valid_q <= in_fire;
                if (in_fire) begin
                    p_q  <= p_d;
                    g_q  <= g_d;
                    gp_q <= gp_d;
                    gg_q <= gg_d;
                    c0_q <= c0_d;
`ifdef CLA_FLAGS_EN
                    a_msb_q <= inA[WIDTH-1];
                    b_msb_q <= b_eff[WIDTH-1];
`endif
                end
            end
            if (adv2) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    sum_q  <= sum_d;
                    cout_q <= cout_d;
`ifdef CLA_FLAGS_EN
                    ovf_q  <= ovf_d;
                    zero_q <= zero_d;
`endif
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
`ifdef CLA_FLAGS_EN
    assign ovf       = ovf_q;
    assign zero      = zero_q;
`endif

endmodule

// File: tb/tb_cla_pipe.sv
// Bench for cla_pipe: directed carries, streaming, backpressure, mid-stream
// reset and a WIDTH/GROUP sweep, all scored against behavioural addition.
module tb_cla_pipe;

    localparam int WIDTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic             in_valid = 1'b0, in_ready, cin = 1'b0, sub = 1'b0;
    logic             out_valid, out_ready = 1'b1, cout;
    logic [WIDTH-1:0] in_a = '0, in_b = '0, sum;
`ifdef CLA_FLAGS_EN
    logic ovf, zero;
`endif

    logic [WIDTH+2:0] exp_q[$];   // {zero, ovf, cout, sum}
    int checks = 0;
    int failures = 0;
    bit sweep_go = 1'b0;

    cla_pipe #(.WIDTH(WIDTH), .GROUP(4)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .inA       (in_a),
        .inB       (in_b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef CLA_FLAGS_EN
        ,
        .ovf       (ovf),
        .zero      (zero)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [WIDTH+2:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                               input logic c, input logic s);
        logic [WIDTH-1:0] bb;
        logic [WIDTH:0]   r;
        logic             v, z;
        bb = s ? ~b : b;
        r  = {1'b0, a} + {1'b0, bb} + (WIDTH+1)'(s ? 1'b1 : c);
        v  = (a[WIDTH-1] == bb[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
        z  = (r[WIDTH-1:0] == '0);
        return {z, v, r};
    endfunction

    // Scoreboard: push on input handshake, pop and compare on output handshake.
    always @(negedge clk) begin
        logic [WIDTH+2:0] e;
        if (rst) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                check("out_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("sum", 64'(sum), 64'(e[WIDTH-1:0]));
                    check("cout", 64'(cout), 64'(e[WIDTH]));
`ifdef CLA_FLAGS_EN
                    check("ovf", 64'(ovf), 64'(e[WIDTH+1]));
                    check("zero", 64'(zero), 64'(e[WIDTH+2]));
`endif
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(in_a, in_b, cin, sub));
        end
    end

    task automatic lat_beat(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c,
                            input logic s, input logic [WIDTH-1:0] exp_sum, input logic exp_cout);
        int lat;
        @(posedge clk); #1;
        in_valid = 1'b1; in_a = a; in_b = b; cin = c; sub = s;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 64'(lat), 64'd2);
        check("dir_sum", 64'(sum), 64'(exp_sum));
        check("dir_cout", 64'(cout), 64'(exp_cout));
    endtask

    task automatic stream(input int n);
        int drops = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            in_a = 16'($urandom()); in_b = 16'($urandom());
            cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (!in_ready) drops++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("stream_ready_drops", 64'(drops), 64'd0);
        repeat (4) @(posedge clk);
        #1;
        check("stream_drained", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic backpressure();
        int acc = 0;
        bit took;
        logic [WIDTH-1:0] snap;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_a = 16'($urandom()); in_b = 16'($urandom()); cin = 1'b1; sub = 1'b0;
        repeat (5) begin
            @(negedge clk);
            took = in_ready;
            if (took) acc++;
            @(posedge clk); #1;
            if (took) begin
                in_a = 16'($urandom()); in_b = 16'($urandom()); sub = 1'($urandom_range(0, 1));
            end
        end
        check("bp_accepts", 64'(acc), 64'd2);
        check("bp_in_ready", 64'(in_ready), 64'd0);
        snap = sum;
        repeat (2) begin
            @(posedge clk); #1;
            check("bp_sum_hold", 64'(sum), 64'(snap));
            check("bp_out_valid_hold", 64'(out_valid), 64'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("bp_drained", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic reset_mid();
        @(posedge clk); #1;
        in_valid = 1'b1; in_a = 16'h1111; in_b = 16'h2222; cin = 1'b0; sub = 1'b0;
        @(posedge clk); #1;
        in_a = 16'h3333; in_b = 16'h0001; sub = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_out_valid", 64'(out_valid), 64'd0);
        check("rst_mid_sum", 64'(sum), 64'd0);
        check("rst_mid_in_ready", 64'(in_ready), 64'd0);
        rst = 1'b0;
        lat_beat(16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_mid_drained", 64'(exp_q.size()), 64'd0);
    endtask

    function automatic int sw_w(input int k);
        case (k)
            0: return 8;
            1: return 16;
            2: return 32;
            default: return 64;
        endcase
    endfunction

    function automatic int sw_g(input int k);
        case (k)
            0: return 4;
            1: return 2;
            2: return 8;
            default: return 4;
        endcase
    endfunction

    for (genvar k = 0; k < 4; k++) begin : g_sw
        localparam int W = sw_w(k);
        localparam int G = sw_g(k);
        logic         iv = 1'b0, ir, ov, orr = 1'b0, c = 1'b0, s = 1'b0, co;
        logic [W-1:0] a = '0, b = '0, sm;
        bit           done = 1'b0;
        logic [W:0]   q[$];
`ifdef CLA_FLAGS_EN
        logic f_ovf, f_zero;
`endif

        cla_pipe #(.WIDTH(W), .GROUP(G)) u_sw (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (iv),
            .in_ready  (ir),
            .inA       (a),
            .inB       (b),
            .cin       (c),
            .sub       (s),
            .out_valid (ov),
            .out_ready (orr),
            .sum       (sm),
            .cout      (co)
`ifdef CLA_FLAGS_EN
            ,
            .ovf       (f_ovf),
            .zero      (f_zero)
`endif
        );

        always @(negedge clk) begin
            logic [W:0] e;
            if (rst) begin
                q.delete();
            end else begin
                if (ov && orr) begin
                    check("sw_expected", 64'(q.size() != 0), 64'd1);
                    if (q.size() != 0) begin
                        e = q.pop_front();
                        check($sformatf("sw%0d_sum", W), 64'(sm), 64'(e[W-1:0]));
                        check($sformatf("sw%0d_cout", W), 64'(co), 64'(e[W]));
                    end
                end
                if (iv && ir) q.push_back({1'b0, a} + {1'b0, (s ? ~b : b)} + (W+1)'(s ? 1'b1 : c));
            end
        end

        initial begin
            bit          took;
            logic [63:0] r;
            took = 1'b0;
            wait (sweep_go);
            for (int i = 0; i < 120; i++) begin
                @(posedge clk); #1;
                if (took || !iv) begin
                    iv = ($urandom_range(0, 3) != 0);
                    r = {$urandom(), $urandom()};
                    a = ($urandom_range(0, 5) == 0) ? '1 : r[W-1:0];
                    r = {$urandom(), $urandom()};
                    b = ($urandom_range(0, 5) == 0) ? '0 : r[W-1:0];
                    c = 1'($urandom_range(0, 1));
                    s = 1'($urandom_range(0, 1));
                end
                orr = ($urandom_range(0, 3) != 0);
                @(negedge clk);
                took = iv && ir;
            end
            @(posedge clk); #1;
            iv = 1'b0;
            orr = 1'b1;
            repeat (4) @(posedge clk);
            #1;
            check($sformatf("sw%0d_drained", W), 64'(q.size()), 64'd0);
            done = 1'b1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_sum", 64'(sum), 64'd0);
        check("rst_cout", 64'(cout), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        lat_beat(16'h1234, 16'h0FFF, 1'b1, 1'b0, 16'h2234, 1'b0);
        lat_beat(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1);
`ifdef CLA_FLAGS_EN
        check("flag_zero", 64'(zero), 64'd1);
`endif
        lat_beat(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0);
        lat_beat(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1);
`ifdef CLA_FLAGS_EN
        check("flag_ovf", 64'(ovf), 64'd1);
`endif
        lat_beat(16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b1);
        lat_beat(16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0);

        stream(100);
        backpressure();
        reset_mid();

        sweep_go = 1'b1;
        n = 0;
        while (!(g_sw[0].done && g_sw[1].done && g_sw[2].done && g_sw[3].done) && n < 5000) begin
            @(posedge clk);
            n++;
        end
        check("sweep_done", 64'({g_sw[3].done, g_sw[2].done, g_sw[1].done, g_sw[0].done}), 64'hF);
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cla_pipe.md
# cla_pipe

Parametrised, two-stage pipelined carry-lookahead adder/subtractor with a valid/ready handshake on both sides. It generalises the team's fixed 8-bit lookahead adder to any width that is a multiple of the group size, using two-level (bit, then group) lookahead. It adds a subtract mode and full backpressure, and sits in the ALU datapath between operand fetch and the result writeback stage.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of GROUP, minimum GROUP.
- GROUP, 4, bits per lookahead group; legal values 2, 4, 8.
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept an operand beat this cycle.
- inA  in  WIDTH  operand A.
- inB  in  WIDTH  operand B.
- cin  in  1  carry-in; used only when sub=0.
- sub  in  1  0: A+B+cin; 1: A−B (cin ignored).
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result.
- cout  out  1  carry out of MSB; in subtract mode 1 = no borrow.
- ovf  out  1  signed overflow (CLA_FLAGS_EN only).
- zero  out  1  sum == 0 (CLA_FLAGS_EN only).

## Operation
- Arithmetic: let b = sub ? ~inB : inB and c0 = sub ? 1 : cin. Result {cout, sum} = inA + b + c0, computed modulo 2^(WIDTH+1).
- Stage 1 (S1): per-bit p = a^b and g = a&b; per-group GP and GG via lookahead. Registers p, g, GP, GG, c0, and the MSB operand signs into S1.
- Stage 2 (S2): group carries from GP/GG/c0 by second-level lookahead. In-group carries use first-level lookahead. sum = p ^ carry. Registers sum, cout and flags into the output register.
- Transfer rules:
  - An input beat is accepted when in_valid & in_ready.
  - A result beat leaves when out_valid & out_ready.
- Advance conditions:
  - adv2 = !out_valid | out_ready.
  - adv1 = !s1_valid | adv2.
  - in_ready = adv1 & !rst.
- Simultaneous accept and emit in the same cycle is required. Sustained throughput is 1 beat/cycle while out_ready is held high.
- Stall: with out_ready=0 and the output full, S1 holds. Once S1 is also full, in_ready=0. Held data and out_valid must not change while stalled.
- No reordering and no drops. Results emerge in acceptance order.

## Timing
- Latency: a beat accepted at edge N presents out_valid=1 with its result after edge N+2, assuming no stall.
- Reset: on any edge with rst=1, the following are cleared:
  - s1_valid=0, out_valid=0, sum=0, cout=0, ovf=0, zero=0.
  - All pipeline contents are discarded.
- in_ready is 0 while rst is high. Reset mid-operation drops in-flight beats with no partial output.
- Outputs are registered. in_ready is the only combinational output, from out_ready, internal valids and rst.
- Boundary carries:
  - all-ones + 0 + cin=1 → sum=0, cout=1.
  - 0 − 0 → sum=0, cout=1.
  - 0 − 1 → all-ones, cout=0.

## Configuration
- CLA_FLAGS_EN defined:
  - ovf and zero ports exist.
  - ovf = (a_msb == b_msb) & (sum_msb != a_msb), using b after inversion.
  - zero = ~|sum.
  - Both are registered alongside sum.
- CLA_FLAGS_EN undefined:
  - ovf and zero ports and their logic are absent.
  - Sum/cout behaviour and timing are identical.

## Structure
- Shared package cla_pkg holds:
  - The legal-GROUP check function.
  - A localparam-derived NGROUPS = WIDTH/GROUP helper.
  - The lookahead function computing (P, G) from p/g vectors, reused at both levels.
- Sub-module cla_group (parameter GROUP):
  - Inputs: p, g, carry-in.
  - Outputs: in-group carries, GP, GG.
  - Instantiated NGROUPS times in S1/S2.
- Elaboration error if WIDTH % GROUP != 0 or GROUP is not legal.

## Test plan
- WIDTH=16, out_ready=1:
  - Add 0x1234+0x0FFF, cin=1 → sum=0x2234, cout=0.
  - Add 0xFFFF+0x0000, cin=1 → sum=0x0000, cout=1, zero=1 (flags build). Each result appears 2 cycles after acceptance.
- Subtract:
  - 0x0005−0x0007 → sum=0xFFFE, cout=0.
  - 0x8000−0x0001 → sum=0x7FFF, cout=1, ovf=1.
- Streaming: 100 back-to-back random beats, out_ready=1 → in_ready stays 1 and results match a reference model in order.
- Backpressure: hold out_ready=0 for 5 cycles while driving in_valid=1.
  - in_ready drops after 2 accepts.
  - sum and out_valid stay stable.
  - Releasing out_ready drains in order with no loss or duplication.
- Reset mid-stream: assert rst with 2 beats in flight → next cycle out_valid=0 and sum=0. The first post-reset beat has latency 2.
- Parameter sweep: WIDTH/GROUP = 8/4, 16/2, 32/8, 64/4 with random operands, sub random → bit-exact against {cout,sum} from behavioural addition.
